fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch

---
 rtl/fetch_unit.sv | 94 +++++++++
 tb/tb_fetch_unit.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Y86-64-style fetch stage: 1 KiB byte-writable instruction memory, cleared on reset,
// plus a combinational decode of icode/ifunc/registers/constant/next-PC at PC_i.
module fetch_unit (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [63:0] PC_i,
  input  logic        imem_wr_en_i,
  input  logic [9:0]  imem_wr_addr_i,
  input  logic [7:0]  imem_wr_data_i,
  output logic [3:0]  icode_o,
  output logic [3:0]  ifunc_o,
  output logic [3:0]  rA_o,
  output logic [3:0]  rB_o,
  output logic [63:0] valC_o,
  output logic [63:0] valP_o,
  output logic        instr_valid_o,
  output logic        imem_error_o
);

  localparam int unsigned MEM_BYTES   = 1024;
  localparam int unsigned AW          = 10;
  localparam int unsigned FETCH_BYTES = 10;

  logic [7:0]  r_mem [MEM_BYTES];
  logic [AW:0] w_addr [FETCH_BYTES];
  logic [7:0]  w_byte [FETCH_BYTES];
  logic        w_pc_ok;
  logic [3:0]  w_icode;
  logic [3:0]  w_ifunc;
  logic        w_valid;
  logic        w_need_regids;
  logic        w_need_valc;
  logic [3:0]  w_len;
  logic [AW:0] w_last;
  logic        w_err;
  logic [63:0] w_valc;

  // Byte-wide memory; reset clears every byte asynchronously.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < MEM_BYTES; i++) r_mem[i] <= 8'h00;
    end else if (imem_wr_en_i) begin
      r_mem[imem_wr_addr_i] <= imem_wr_data_i;
    end
  end

  // Fetch window: bytes past the top of memory read as zero and never wrap.
  always_comb begin
    w_pc_ok = (PC_i[63:AW] == '0);
    for (int k = 0; k < FETCH_BYTES; k++) begin
      w_addr[k] = {1'b0, PC_i[AW-1:0]} + (AW+1)'(k);
      w_byte[k] = 8'h00;
      if (w_pc_ok && !w_addr[k][AW]) w_byte[k] = r_mem[w_addr[k][AW-1:0]];
    end
  end

  always_comb begin
    w_icode       = w_byte[0][7:4];
    w_ifunc       = w_byte[0][3:0];
    w_valid       = (w_icode <= 4'hB);
    w_need_regids = w_icode inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB};
    w_need_valc   = w_icode inside {4'h3, 4'h4, 4'h5, 4'h7, 4'h8};
    w_len         = 4'd1 + 4'(w_need_regids) + (w_need_valc ? 4'd8 : 4'd0);
    // Last byte address is only meaningful when PC itself is in range, so 11 bits suffice.
    w_last        = {1'b0, PC_i[AW-1:0]} + (AW+1)'(w_len) - (AW+1)'(1);
    w_err         = !w_pc_ok || w_last[AW];
    w_valc        = '0;
    for (int j = 0; j < 8; j++) begin
      w_valc[8*j +: 8] = w_need_regids ? w_byte[j+2] : w_byte[j+1];
    end
  end

  always_comb begin
    icode_o       = w_icode;
    ifunc_o       = w_ifunc;
    rA_o          = w_need_regids ? w_byte[1][7:4] : 4'hF;
    rB_o          = w_need_regids ? w_byte[1][3:0] : 4'hF;
    valC_o        = w_need_valc ? w_valc : 64'd0;
    valP_o        = PC_i + 64'(w_len);
    instr_valid_o = w_valid;
    imem_error_o  = w_err;
    // Out-of-range fetch degrades to a nop at PC.
    if (w_err) begin
      icode_o       = 4'h1;
      ifunc_o       = 4'h0;
      rA_o          = 4'hF;
      rB_o          = 4'hF;
      valC_o        = 64'd0;
      valP_o        = PC_i + 64'd1;
      instr_valid_o = 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vectors plus random writes/fetches against a byte-array model.
module tb_fetch_unit;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic [63:0] PC_i = '0;
  logic        imem_wr_en_i = 1'b0;
  logic [9:0]  imem_wr_addr_i = '0;
  logic [7:0]  imem_wr_data_i = '0;
  logic [3:0]  icode_o, ifunc_o, rA_o, rB_o;
  logic [63:0] valC_o, valP_o;
  logic        instr_valid_o, imem_error_o;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;
  logic [7:0]  m_mem [1024];

  fetch_unit dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .PC_i(PC_i),
    .imem_wr_en_i(imem_wr_en_i), .imem_wr_addr_i(imem_wr_addr_i), .imem_wr_data_i(imem_wr_data_i),
    .icode_o(icode_o), .ifunc_o(ifunc_o), .rA_o(rA_o), .rB_o(rB_o),
    .valC_o(valC_o), .valP_o(valP_o), .instr_valid_o(instr_valid_o), .imem_error_o(imem_error_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] mbyte(input logic [63:0] a);
    return (a < 64'd1024) ? m_mem[a[9:0]] : 8'h00;
  endfunction

  // Instruction length straight from the opcode table; illegal codes count as 1 byte.
  function automatic int instr_len(input logic [3:0] ic);
    case (ic)
      4'h0, 4'h1, 4'h9:         return 1;
      4'h2, 4'h6, 4'hA, 4'hB:   return 2;
      4'h3, 4'h4, 4'h5:         return 10;
      4'h7, 4'h8:               return 9;
      default:                  return 1;
    endcase
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 1024; i++) m_mem[i] = 8'h00;
  endtask

  task automatic wr(input int addr, input logic [7:0] data);
    @(negedge clk_i);
    imem_wr_en_i   = 1'b1;
    imem_wr_addr_i = 10'(addr);
    imem_wr_data_i = data;
    @(posedge clk_i);
    if (rst_n_i) m_mem[addr] = data;
    #1 imem_wr_en_i = 1'b0;
  endtask

  task automatic load(input int addr, input int n, input logic [79:0] bytes);
    for (int i = 0; i < n; i++) wr(addr + i, bytes[79-8*i -: 8]);
  endtask

  task automatic check_fetch(input string tag, input logic [63:0] pc);
    logic [3:0]  ic, e_ic, e_if, e_ra, e_rb;
    logic [63:0] e_valc, e_valp;
    logic        e_valid, e_err;
    int          len, regids;
    logic [7:0]  b1;
    @(negedge clk_i);
    PC_i = pc;
    #2;
    ic      = mbyte(pc)[7:4];
    e_valid = (ic < 4'd12);
    len     = instr_len(ic);
    regids  = (len == 2 || len == 10) ? 1 : 0;
    if (pc > 64'd1023) e_err = 1'b1;
    else               e_err = (pc + 64'(len) - 64'd1) > 64'd1023;
    b1      = mbyte(pc + 64'd1);
    e_ic    = ic;
    e_if    = mbyte(pc)[3:0];
    e_ra    = regids ? b1[7:4] : 4'hF;
    e_rb    = regids ? b1[3:0] : 4'hF;
    e_valc  = '0;
    if (len >= 9)
      for (int i = 0; i < 8; i++)
        e_valc |= 64'(mbyte(pc + 64'd1 + 64'(regids) + 64'(i))) << (8*i);
    e_valp  = pc + 64'(len);
    if (e_err) begin
      e_ic = 4'h1; e_if = 4'h0; e_ra = 4'hF; e_rb = 4'hF;
      e_valc = '0; e_valp = pc + 64'd1; e_valid = 1'b1;
    end
    check({tag, ".icode"}, 64'(icode_o), 64'(e_ic));
    check({tag, ".ifunc"}, 64'(ifunc_o), 64'(e_if));
    check({tag, ".rA"},    64'(rA_o),    64'(e_ra));
    check({tag, ".rB"},    64'(rB_o),    64'(e_rb));
    check({tag, ".valC"},  valC_o,       e_valc);
    check({tag, ".valP"},  valP_o,       e_valp);
    check({tag, ".valid"}, 64'(instr_valid_o), 64'(e_valid));
    check({tag, ".err"},   64'(imem_error_o),  64'(e_err));
  endtask

  task automatic mid_cycle_reset();
    @(posedge clk_i);
    #2 rst_n_i = 1'b0;
    clear_model();
    #1;
  endtask

  initial begin
    logic [63:0] pc;
    clear_model();
    repeat (3) @(posedge clk_i);
    @(negedge clk_i) rst_n_i = 1'b1;

    check_fetch("rst", 64'd0);
    check("rst.valP_c", valP_o, 64'd1);

    load(0, 10, 80'h30F30A00000000000000);
    check_fetch("irmov", 64'd0);
    check("irmov.rB_c", 64'(rB_o), 64'd3);
    check("irmov.valC_c", valC_o, 64'h000000000000000A);
    check("irmov.valP_c", valP_o, 64'd10);

    load(46, 9, 80'h70400000000000000000);
    check_fetch("jxx", 64'd46);
    check("jxx.valC_c", valC_o, 64'h40);
    check("jxx.valP_c", valP_o, 64'd55);
    wr(64, 8'h90);
    check_fetch("ret", 64'd64);
    check("ret.valP_c", valP_o, 64'd65);

    load(20, 2, 80'h60230000000000000000);
    check_fetch("opq", 64'd20);
    check("opq.rA_c", 64'(rA_o), 64'd2);
    check("opq.valP_c", valP_o, 64'd22);
    wr(65, 8'hE0);
    check_fetch("bad_ic", 64'd65);
    check("bad_ic.valid_c", 64'(instr_valid_o), 64'd0);
    check("bad_ic.valP_c", valP_o, 64'd66);

    check_fetch("pc1024", 64'd1024);
    check("pc1024.err_c", 64'(imem_error_o), 64'd1);
    check("pc1024.valP_c", valP_o, 64'd1025);
    wr(1020, 8'h30);
    check_fetch("pc1020", 64'd1020);
    check("pc1020.err_c", 64'(imem_error_o), 64'd1);
    wr(1023, 8'h10);
    check_fetch("pc1023", 64'd1023);
    check("pc1023.err_c", 64'(imem_error_o), 64'd0);
    check("pc1023.valP_c", valP_o, 64'd1024);
    check_fetch("pcmax", 64'hFFFF_FFFF_FFFF_FFFF);
    check("pcmax.valP_c", valP_o, 64'd0);
    check_fetch("pcnear", 64'hFFFF_FFFF_FFFF_FFF8);

    // Writes while reset is held must be dropped.
    @(negedge clk_i) rst_n_i = 1'b0;
    clear_model();
    wr(5, 8'h30);
    @(negedge clk_i) rst_n_i = 1'b1;
    check_fetch("rst_wr", 64'd5);

    wr(0, 8'h10);
    check_fetch("pre_arst", 64'd0);
    mid_cycle_reset();
    check("arst.icode_c", 64'(icode_o), 64'd0);
    @(negedge clk_i) rst_n_i = 1'b1;
    check_fetch("arst", 64'd0);

    for (int it = 0; it < 800; it++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: wr(int'($urandom_range(0, 1023)), 8'($urandom));
        4:          check_fetch("rnd_edge", 64'd1014 + 64'($urandom_range(0, 14)));
        5:          check_fetch("rnd_far", {32'($urandom), 32'($urandom)});
        6: begin
          if ($urandom_range(0, 19) == 0) begin
            mid_cycle_reset();
            @(negedge clk_i) rst_n_i = 1'b1;
          end
          check_fetch("rnd_post", 64'($urandom_range(0, 1023)));
        end
        default: begin
          pc = 64'($urandom_range(0, 1023));
          check_fetch("rnd", pc);
        end
      endcase
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
